// File: rtl/elixirchip_es1_spu_seq_pkg.sv
// Shared definitions for ES1 SPU multi-pass sequencers.
package elixirchip_es1_spu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/elixirchip_es1_spu_op_add.sv
// ES1 SPU add op: DATA_BITS-wide add with carry-in, pipelined over LATENCY stages.
module elixirchip_es1_spu_op_add #(
  parameter int                   LATENCY         = 1,
  parameter int                   DATA_BITS       = 8,
  parameter bit                   IMMEDIATE_DATA0 = 1'b0,
  parameter bit                   IMMEDIATE_DATA1 = 1'b0,
  parameter bit                   IMMEDIATE_CARRY = 1'b0,
  parameter logic [DATA_BITS-1:0] IMM_DATA0       = '0,
  parameter logic [DATA_BITS-1:0] IMM_DATA1       = '0,
  parameter bit                   IMM_CARRY       = 1'b0,
  parameter bit                   CLEAR_DATA      = 1'b0,
  parameter bit                   CLEAR_CARRY     = 1'b0,
  parameter bit                   CLEAR_MSB_C     = 1'b0,
  parameter                       DEVICE          = "RTL",
  parameter                       SIMULATION      = "false",
  parameter                       DEBUG           = "false"
) (
  input  logic                 reset,
  input  logic                 clk,
  input  logic                 cke,
  input  logic [DATA_BITS-1:0] s_data0,
  input  logic [DATA_BITS-1:0] s_data1,
  input  logic                 s_carry,
  input  logic                 s_clear,
  input  logic                 s_valid,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_carry,
  output logic                 m_msb_c,
  output logic                 m_valid
);

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 carry;
    logic                 msb_c;
    logic                 valid;
  } stage_t;

  logic [DATA_BITS-1:0] a_val;
  logic [DATA_BITS-1:0] b_val;
  logic                 c_val;
  logic [DATA_BITS:0]   sum;
  logic                 clear;
  stage_t               stage_next;
  stage_t               stage_reg [LATENCY];

  always_comb begin
    a_val = IMMEDIATE_DATA0 ? IMM_DATA0 : s_data0;
    b_val = IMMEDIATE_DATA1 ? IMM_DATA1 : s_data1;
    c_val = IMMEDIATE_CARRY ? IMM_CARRY : s_carry;
    sum   = {1'b0, a_val} + {1'b0, b_val} + {{DATA_BITS{1'b0}}, c_val};
    clear = s_valid && s_clear;
    stage_next.valid = s_valid;
    stage_next.data  = (CLEAR_DATA && clear) ? '0 : sum[DATA_BITS-1:0];
    stage_next.carry = (CLEAR_CARRY && clear) ? 1'b0 : sum[DATA_BITS];
    // Carry into the msb falls out of the msb sum bit and the two msb operand bits.
    stage_next.msb_c = (CLEAR_MSB_C && clear) ? 1'b0
                     : sum[DATA_BITS-1] ^ a_val[DATA_BITS-1] ^ b_val[DATA_BITS-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) stage_reg[i] <= '0;
    end else if (cke) begin
      for (int i = LATENCY - 1; i > 0; i--) stage_reg[i] <= stage_reg[i-1];
      stage_reg[0] <= stage_next;
    end
  end

  assign m_data  = stage_reg[LATENCY-1].data;
  assign m_carry = stage_reg[LATENCY-1].carry;
  assign m_msb_c = stage_reg[LATENCY-1].msb_c;
  assign m_valid = stage_reg[LATENCY-1].valid;

endmodule

// File: rtl/elixirchip_es1_spu_seq_add_multiword.sv
// Multi-word adder: one add-op pass per word, LSW first, carry chained between passes.
module elixirchip_es1_spu_seq_add_multiword
  import elixirchip_es1_spu_seq_pkg::*;
#(
  parameter int ADD_LATENCY = 1,
  parameter int WORD_BITS   = 8,
  parameter int WORDS       = 4,
  parameter     DEVICE      = "RTL",
  parameter     SIMULATION  = "false",
  parameter     DEBUG       = "false"
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       cke,
  input  logic [WORDS*WORD_BITS-1:0] s_data0,
  input  logic [WORDS*WORD_BITS-1:0] s_data1,
  input  logic                       s_carry,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [WORDS*WORD_BITS-1:0] m_data,
  output logic                       m_carry,
  output logic                       m_overflow,
  output logic                       m_valid,
  input  logic                       m_ready
);

  localparam int IDX_BITS = idx_bits(WORDS);
  localparam int CNT_BITS = $clog2(ADD_LATENCY + 1);

  seq_state_t                       state_reg;
  logic [IDX_BITS-1:0]              word_idx_reg;
  logic [CNT_BITS-1:0]              wait_cnt_reg;
  logic                             carry_reg;
  logic                             s_ready_reg;
  logic                             m_valid_reg;
  logic                             m_carry_reg;
  logic                             m_overflow_reg;
  logic [WORDS-1:0][WORD_BITS-1:0]  op0_reg;
  logic [WORDS-1:0][WORD_BITS-1:0]  op1_reg;
  logic [WORDS-1:0][WORD_BITS-1:0]  result_reg;

  logic [WORD_BITS-1:0] add_m_data;
  logic                 add_m_carry;
  logic                 add_m_msb_c;
  logic                 add_m_valid;
  logic                 last_wait;

  elixirchip_es1_spu_op_add #(
    .LATENCY     (ADD_LATENCY),
    .DATA_BITS   (WORD_BITS),
    .CLEAR_DATA  (1'b0),
    .CLEAR_CARRY (1'b0),
    .CLEAR_MSB_C (1'b0),
    .DEVICE      (DEVICE),
    .SIMULATION  (SIMULATION),
    .DEBUG       (DEBUG)
  ) u_add (
    .reset   (~reset_n),
    .clk     (clk),
    .cke     (cke),
    .s_data0 (op0_reg[word_idx_reg]),
    .s_data1 (op1_reg[word_idx_reg]),
    .s_carry (carry_reg),
    .s_clear (1'b0),
    .s_valid (state_reg == ISSUE),
    .m_data  (add_m_data),
    .m_carry (add_m_carry),
    .m_msb_c (add_m_msb_c),
    .m_valid (add_m_valid)
  );

  assign last_wait = (wait_cnt_reg == CNT_BITS'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      word_idx_reg   <= '0;
      wait_cnt_reg   <= '0;
      carry_reg      <= 1'b0;
      s_ready_reg    <= 1'b0;
      m_valid_reg    <= 1'b0;
      m_carry_reg    <= 1'b0;
      m_overflow_reg <= 1'b0;
      op0_reg        <= '0;
      op1_reg        <= '0;
      result_reg     <= '0;
    end else if (cke) begin
      case (state_reg)
        IDLE: begin
          s_ready_reg <= 1'b1;
          if (s_valid && s_ready_reg) begin
            op0_reg      <= s_data0;
            op1_reg      <= s_data1;
            carry_reg    <= s_carry;
            word_idx_reg <= '0;
            s_ready_reg  <= 1'b0;
            state_reg    <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt_reg <= CNT_BITS'(ADD_LATENCY);
          state_reg    <= WAIT;
        end
        WAIT: begin
          wait_cnt_reg <= wait_cnt_reg - CNT_BITS'(1);
          // The op output only lines up with this pass on the final wait cycle.
          if (last_wait && add_m_valid) begin
            result_reg[word_idx_reg] <= add_m_data;
            carry_reg                <= add_m_carry;
            if (word_idx_reg == IDX_BITS'(WORDS - 1)) begin
              m_carry_reg    <= add_m_carry;
              m_overflow_reg <= add_m_carry ^ add_m_msb_c;
              m_valid_reg    <= 1'b1;
              state_reg      <= DONE;
            end else begin
              word_idx_reg <= word_idx_reg + IDX_BITS'(1);
              state_reg    <= ISSUE;
            end
          end
        end
        DONE: begin
          if (m_ready) begin
            m_valid_reg <= 1'b0;
            s_ready_reg <= 1'b1;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign s_ready    = s_ready_reg;
  assign m_data     = result_reg;
  assign m_carry    = m_carry_reg;
  assign m_overflow = m_overflow_reg;
  assign m_valid    = m_valid_reg;

endmodule
